// File: rtl/fpcvt_pkg.sv
// Shared widths, FSM encoding and constants for the 12-bit sample to 8-bit float converter.
package fpcvt_pkg;

  localparam int IN_W  = 12;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;

  // Leading-one position after normalisation, and the round bit just below Sig.
  localparam int NORM_BIT = IN_W - 2;
  localparam int F_BIT    = NORM_BIT - SIG_W;

  localparam logic [EXP_W-1:0] E_MAX   = 3'd7;
  localparam logic [IN_W-1:0]  MAG_MAX = 12'h7FF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_NORM  = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [SIG_W-1:0] sig;
  } fp8_t;

  // Magnitude of a two's-complement sample; the most negative value clamps to MAG_MAX.
  function automatic logic [IN_W-1:0] abs_sat(input logic [IN_W-1:0] d);
    logic [IN_W-1:0] neg;
    neg = ~d + 1'b1;
    if (!d[IN_W-1])
      return d;
    else if (neg[IN_W-1])
      return MAG_MAX;
    else
      return neg;
  endfunction

endpackage

// File: rtl/fpcvt_seq_ctrl_if.sv
// Producer-side and consumer-side handshakes of the converter, plus its busy flag.
interface fpcvt_seq_ctrl_if;
  import fpcvt_pkg::*;

  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             out_s;
  logic [EXP_W-1:0] out_e;
  logic [SIG_W-1:0] out_sig;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_s, out_e, out_sig, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_s, out_e, out_sig, busy
  );

endinterface

// File: rtl/fpcvt_round_step.sv
// Round-half-up of the normalised significand with exponent bump on carry and saturation at E_MAX.
module fpcvt_round_step
  import fpcvt_pkg::*;
(
  input  logic [EXP_W-1:0] e_in,
  input  logic [SIG_W-1:0] sig_in,
  input  logic             f_in,
  output logic [EXP_W-1:0] e_out,
  output logic [SIG_W-1:0] sig_out
);

  logic [SIG_W:0] sum;

  always_comb begin
    sum     = {1'b0, sig_in} + {{SIG_W{1'b0}}, f_in};
    e_out   = e_in;
    sig_out = sum[SIG_W-1:0];
    if (sum[SIG_W]) begin
      if (e_in == E_MAX) begin
        e_out   = E_MAX;
        sig_out = '1;
      end else begin
        e_out   = e_in + {{(EXP_W-1){1'b0}}, 1'b1};
        sig_out = {1'b1, {(SIG_W-1){1'b0}}};
      end
    end
  end

endmodule

// File: rtl/fpcvt_seq_ctrl.sv
// Sequenced converter: capture, sign/magnitude, one normalising shift per clock, round, hold until taken.
module fpcvt_seq_ctrl
  import fpcvt_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fpcvt_seq_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic [IN_W-1:0]  data_q, data_d;
  logic [IN_W-1:0]  mag_q, mag_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic             s_q, s_d;
  fp8_t             res_q, res_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [EXP_W-1:0] e_rnd;
  logic [SIG_W-1:0] sig_rnd;

  fpcvt_round_step u_round (
    .e_in    (e_q),
    .sig_in  (mag_q[NORM_BIT -: SIG_W]),
    .f_in    (mag_q[F_BIT]),
    .e_out   (e_rnd),
    .sig_out (sig_rnd)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mag_d   = mag_q;
    e_d     = e_q;
    s_d     = s_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        s_d     = data_q[IN_W-1];
        mag_d   = abs_sat(data_q);
        e_d     = E_MAX;
        state_d = ST_NORM;
      end
      ST_NORM: begin
        // A zero magnitude never finds a leading one, so e bottoming out ends the walk.
        if (!mag_q[NORM_BIT] && (e_q != '0)) begin
          mag_d = mag_q << 1;
          e_d   = e_q - 1'b1;
        end else begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        res_d.s   = s_q;
        res_d.e   = e_rnd;
        res_d.sig = sig_rnd;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Handshake flags are registered copies of the next state so they never glitch.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      mag_q       <= '0;
      e_q         <= '0;
      s_q         <= 1'b0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      mag_q       <= mag_d;
      e_q         <= e_d;
      s_q         <= s_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_s     = res_q.s;
  assign bus.out_e     = res_q.e;
  assign bus.out_sig   = res_q.sig;

endmodule

// File: tb/tb_fpcvt_seq_ctrl.sv
// Bench for fpcvt_seq_ctrl: directed corner cases plus random samples against an arithmetic reference.
module tb_fpcvt_seq_ctrl;

  logic clk = 1'b0;
  logic rst;

  fpcvt_seq_ctrl_if bus ();

  fpcvt_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Float value from the number rules: leading-one position, shift count, round-half-up.
  function automatic logic [7:0] ref_cvt(input logic [11:0] d, output int nsh);
    int v, mag, msb, e, scaled, sig, f, s;
    v   = int'($signed(d));
    s   = (v < 0) ? 1 : 0;
    mag = (v < 0) ? -v : v;
    if (mag > 2047) mag = 2047;
    msb = -1;
    for (int b = 0; b < 12; b++)
      if (mag >= (1 << b)) msb = b;
    if (msb < 0)            nsh = 7;
    else if (10 - msb > 7)  nsh = 7;
    else                    nsh = 10 - msb;
    e      = 7 - nsh;
    scaled = mag * (1 << nsh);
    sig    = (scaled / 128) % 16;
    f      = (scaled / 64) % 2;
    sig    = sig + f;
    if (sig == 16) begin
      if (e == 7) sig = 15;
      else begin
        e   = e + 1;
        sig = 8;
      end
    end
    return 8'((s << 7) | (e << 4) | sig);
  endfunction

  function automatic int got_res();
    return int'({bus.out_s, bus.out_e, bus.out_sig});
  endfunction

  // Called at #1 after a rising edge; leaves the bench at the same phase.
  task automatic xfer(input logic [11:0] d, input int hold, input bit poke);
    logic [7:0] exp_r;
    int nsh, lat, w;
    exp_r = ref_cvt(d, nsh);
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check("in_ready_idle", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 12'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("result", got_res(), int'(exp_r));
    check("latency", lat, 3 + nsh);
    check("in_ready_done", int'(bus.in_ready), 0);
    check("busy_done", int'(bus.busy), 1);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 12'($urandom);
      end
      @(posedge clk); #1;
      check("hold_valid", int'(bus.out_valid), 1);
      check("hold_result", got_res(), int'(exp_r));
      check("hold_in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("handoff_valid", int'(bus.out_valid), 0);
    check("handoff_in_ready", int'(bus.in_ready), 1);
    check("handoff_busy", int'(bus.busy), 0);
    $display("xfer in=%03h res=%02h exp=%02h lat=%0d hold=%0d", d, got_res(), exp_r, lat, hold);
  endtask

  initial begin
    int seen;
    logic [11:0] d;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #12;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_result", got_res(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    xfer(12'd0,   0, 1'b0);
    xfer(12'd56,  1, 1'b0);
    xfer(12'd125, 2, 1'b0);
    xfer(12'h7FF, 0, 1'b0);
    xfer(12'h800, 1, 1'b0);
    xfer(12'hFC8, 0, 1'b0);
    xfer(12'd1,   0, 1'b0);
    xfer(12'hFFF, 0, 1'b0);

    // Long stall with a competing sample offered throughout.
    xfer(12'd125, 20, 1'b1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("single_handoff", seen, 0);

    // Asynchronous reset in the middle of normalisation.
    bus.in_valid = 1'b1;
    bus.in_data  = 12'd1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", int'(bus.in_ready), 1);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_result", got_res(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    xfer(12'd56, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) begin
        d = 12'($urandom_range(0, 40));
        if ($urandom_range(0, 1) == 1) d = -d;
      end else begin
        d = 12'($urandom);
      end
      xfer(d, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
